// File: rtl/shift_pipe_ctrl.sv
// Parametrised WIDTH x DEPTH capture pipeline advanced on a divided tick, with manual/auto/rotate/clear modes.
// Define SHIFT_PIPE_HEX_EN to drive hex_in/hex_out from an active-low 7-segment decoder (blank otherwise).
module shift_pipe_ctrl #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 5,
    parameter int TICK_DIV = 150000000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             din,
    input  logic                         button,
    input  logic [1:0]                   mode,
    output logic [WIDTH*DEPTH-1:0]       stages,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         full,
    output logic                         step,
    output logic                         pending,
    output logic [6:0]                   hex_in,
    output logic [6:0]                   hex_out
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_CLEAR  = 2'd3
    } mode_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic             btn_meta;
    logic             btn_sync;
    logic             btn_prev;
    logic             press;
    state_t           state;
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [OCC_W-1:0] occ;
    logic             step_q;
    logic             do_shift;
    logic             do_rotate;
    logic             do_clear;

    assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

    // NOTE: sequential state is written with <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Button idles high; a press is the synchronised falling edge, so holding it down yields one press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 1'b1;
            btn_sync <= 1'b1;
            btn_prev <= 1'b1;
        end else begin
            btn_meta <= button;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
        end
    end

    assign press = btn_prev & ~btn_sync;

    // NOTE: every output of this block gets a default first, otherwise the non-tick path would infer latches.
    always_comb begin
        do_shift  = 1'b0;
        do_rotate = 1'b0;
        do_clear  = 1'b0;
        if (tick) begin
            case (mode_t'(mode))
                MODE_MANUAL: do_shift  = (state == PENDING);
                MODE_AUTO:   do_shift  = 1'b1;
                MODE_ROTATE: do_rotate = (state == PENDING);
                MODE_CLEAR:  do_clear  = 1'b1;
                default:     do_shift  = 1'b0;
            endcase
        end
    end

    // NOTE: the stage array is made of plain flops (not a RAM), so it can and must be cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            occ    <= '0;
            step_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            step_q <= do_shift | do_rotate | do_clear;

            // Every tick consumes a pending request; a press landing on an idle tick waits for the next one.
            if (tick) begin
                state <= (state == IDLE && press) ? PENDING : IDLE;
            end else if (press) begin
                state <= PENDING;
            end

            if (do_clear) begin
                occ <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else if (do_shift || do_rotate) begin
                stage_q[0] <= do_rotate ? stage_q[DEPTH-1] : din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
                if (do_shift && occ != OCC_W'(DEPTH)) begin
                    occ <= occ + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flatten
        assign stages[g*WIDTH +: WIDTH] = stage_q[g];
    end

    assign dout      = stage_q[DEPTH-1];
    assign occupancy = occ;
    assign full      = (occ == OCC_W'(DEPTH));
    assign step      = step_q;
    assign pending   = (state == PENDING);

`ifdef SHIFT_PIPE_HEX_EN
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    logic [3:0] nib_in;
    logic [3:0] nib_out;

    if (WIDTH >= 4) begin : g_nib_wide
        assign nib_in  = din[3:0];
        assign nib_out = stage_q[DEPTH-1][3:0];
    end else begin : g_nib_narrow
        assign nib_in  = {{(4-WIDTH){1'b0}}, din};
        assign nib_out = {{(4-WIDTH){1'b0}}, stage_q[DEPTH-1]};
    end

    assign hex_in  = hex7(nib_in);
    assign hex_out = hex7(nib_out);
`else
    assign hex_in  = 7'h7F;
    assign hex_out = 7'h7F;
`endif

endmodule

// File: tb/tb_shift_pipe_ctrl.sv
// Scoreboard bench for shift_pipe_ctrl: a transaction model pushes the expected pipeline image per action,
// and a step-triggered monitor pops and compares it.
module tb_shift_pipe_ctrl;

    localparam int WIDTH    = 4;
    localparam int DEPTH    = 5;
    localparam int TICK_DIV = 4;
    localparam int OCC_W    = $clog2(DEPTH + 1);

    logic                   clk;
    logic                   rst_n;
    logic [WIDTH-1:0]       din;
    logic                   button;
    logic [1:0]             mode;
    logic [WIDTH*DEPTH-1:0] stages;
    logic [WIDTH-1:0]       dout;
    logic [OCC_W-1:0]       occupancy;
    logic                   full;
    logic                   step;
    logic                   pending;
    logic [6:0]             hex_in;
    logic [6:0]             hex_out;

    shift_pipe_ctrl #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .button    (button),
        .mode      (mode),
        .stages    (stages),
        .dout      (dout),
        .occupancy (occupancy),
        .full      (full),
        .step      (step),
        .pending   (pending),
        .hex_in    (hex_in),
        .hex_out   (hex_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH*DEPTH-1:0] img;
        logic [OCC_W-1:0]       occ;
    } exp_t;

    exp_t             sb_q [$];
    logic [WIDTH-1:0] model [DEPTH];
    int               model_occ;
    int               total;
    int               bad;
    int               step_count;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [WIDTH*DEPTH-1:0] model_image();
        logic [WIDTH*DEPTH-1:0] img;
        for (int i = 0; i < DEPTH; i++) begin
            img[i*WIDTH +: WIDTH] = model[i];
        end
        return img;
    endfunction

    task automatic push_expected();
        exp_t e;
        e.img = model_image();
        e.occ = OCC_W'(model_occ);
        sb_q.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        model_occ = 0;
    endtask

    task automatic model_shift(input logic [WIDTH-1:0] d);
        for (int i = DEPTH - 1; i > 0; i--) model[i] = model[i-1];
        model[0] = d;
        if (model_occ < DEPTH) model_occ++;
        push_expected();
    endtask

    task automatic model_rotate();
        logic [WIDTH-1:0] last;
        last = model[DEPTH-1];
        for (int i = DEPTH - 1; i > 0; i--) model[i] = model[i-1];
        model[0] = last;
        push_expected();
    endtask

    task automatic model_clear();
        model_reset();
        push_expected();
    endtask

    // Each step strobe must match exactly one queued expectation.
    always @(negedge clk) begin
        if (rst_n && step) begin
            exp_t e;
            step_count++;
            if (sb_q.size() == 0) begin
                check("unexpected_step", step, 1'b0);
            end else begin
                e = sb_q.pop_front();
                check("sb_stages", stages, e.img);
                check("sb_occupancy", occupancy, e.occ);
                check("sb_full", full, (e.occ == OCC_W'(DEPTH)));
                check("sb_dout", dout, e.img[WIDTH*DEPTH-1 -: WIDTH]);
            end
        end
    end

    task automatic wait_step(input string tag, input int budget, output int cycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step && n < budget);
        if (!step) check({tag, "_step_timeout"}, step, 1'b1);
        cycles = n;
    endtask

    task automatic press_and_wait(input string tag);
        int n;
        n = 0;
        button = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!pending && n < 10);
        check({tag, "_pending"}, pending, 1'b1);
        button = 1'b1;
        wait_step(tag, 20, n);
        @(negedge clk);
        check({tag, "_step_once"}, step, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        logic [WIDTH-1:0] manual_vals [5];

        total      = 0;
        bad        = 0;
        step_count = 0;
        rst_n      = 1'b0;
        din        = '0;
        button     = 1'b1;
        mode       = 2'd0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_stages", stages, '0);
        check("rst_occupancy", occupancy, '0);
        check("rst_full", full, 1'b0);
        check("rst_pending", pending, 1'b0);
        check("rst_step", step, 1'b0);
`ifdef SHIFT_PIPE_HEX_EN
        check("rst_hex_in", hex_in, 7'h40);
        check("rst_hex_out", hex_out, 7'h40);
`else
        check("rst_hex_in", hex_in, 7'h7F);
        check("rst_hex_out", hex_out, 7'h7F);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // MANUAL: fill the pipe, then push one more into a full pipe.
        manual_vals = '{4'h3, 4'h5, 4'h7, 4'h9, 4'hB};
        foreach (manual_vals[k]) begin
            din = manual_vals[k];
            model_shift(manual_vals[k]);
            press_and_wait("manual");
        end
        check("manual_dout", dout, 4'h3);
        check("manual_full", full, 1'b1);

        din = 4'hC;
        model_shift(4'hC);
        press_and_wait("manual_sat");
        check("sat_dout", dout, 4'h5);
        check("sat_occupancy", occupancy, 3'd5);

        // Three presses land on cycles T+4 (idle tick), T+6 and T+8 (pending tick): one shift only.
        base = step_count;
        din  = 4'hD;
        model_shift(4'hD);
        button = 1'b0;
        @(negedge clk); button = 1'b1;
        @(negedge clk); button = 1'b0;
        @(negedge clk); button = 1'b1;
        @(negedge clk); button = 1'b0;
        @(negedge clk); button = 1'b1;
        repeat (16) @(negedge clk);
        check("collapse_steps", step_count - base, 1);

        // A long hold is a single press.
        base = step_count;
        din  = 4'hE;
        model_shift(4'hE);
        button = 1'b0;
        repeat (20) @(negedge clk);
        button = 1'b1;
        repeat (16) @(negedge clk);
        check("hold_steps", step_count - base, 1);

        // AUTO: shift every tick without presses.
        din  = 4'hA;
        mode = 2'd1;
        for (int k = 0; k < DEPTH; k++) model_shift(4'hA);
        for (int k = 0; k < DEPTH; k++) begin
            wait_step("auto", 12, n);
            if (k > 0) check("auto_period", n, TICK_DIV);
        end
        mode = 2'd0;
        check("auto_all_a", stages, {DEPTH{4'hA}});
        check("auto_full", full, 1'b1);

        // CLEAR on the next tick.
        mode = 2'd3;
        model_clear();
        wait_step("clear", 12, n);
        mode = 2'd0;
        check("clear_stages", stages, '0);
        check("clear_occupancy", occupancy, '0);
        repeat (2) @(negedge clk);

        // ROTATE after preloading 1..5 (stage0 = 5).
        for (int v = 1; v <= DEPTH; v++) begin
            din = WIDTH'(v);
            model_shift(WIDTH'(v));
            press_and_wait("preload");
        end
        mode = 2'd2;
        model_rotate();
        press_and_wait("rotate");
        mode = 2'd0;
        check("rotate_stage0", stages[WIDTH-1:0], 4'h1);
        check("rotate_stage1", stages[2*WIDTH-1:WIDTH], 4'h5);
        check("rotate_dout", dout, 4'h2);
        check("rotate_occupancy", occupancy, 3'd5);

        // Async reset while a request is pending discards it.
        din    = 4'hF;
        button = 1'b0;
        n      = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pending && n < 10);
        check("rstmid_pending_seen", pending, 1'b1);
        rst_n  = 1'b0;
        button = 1'b1;
        model_reset();
        @(negedge clk);
        check("rstmid_pending", pending, 1'b0);
        check("rstmid_stages", stages, model_image());
        @(negedge clk);
        rst_n = 1'b1;
        base  = step_count;
        repeat (12) @(negedge clk);
        check("rstmid_no_step", step_count - base, 0);
        check("rstmid_stages_after", stages, model_image());
        check("rstmid_occupancy", occupancy, OCC_W'(model_occ));
        check("rstmid_pending_after", pending, 1'b0);

        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
